// File: rtl/serial_deserializer_if.sv
// +----------------------------------------------------------------------------+
// | serial_deserializer_if : serial-in / word-out handshake bundle              |
// | Optional: DESER_PARITY_EN adds parity_err.      Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             msb_first;
    logic             bit_valid;
    logic             sin;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             overrun;
    logic             clr_overrun;
`ifdef DESER_PARITY_EN
    logic             parity_err;

    modport master (
        output start, msb_first, bit_valid, sin, data_ready, clr_overrun,
        input  data_out, data_valid, busy, overrun, parity_err
    );

    modport slave (
        input  start, msb_first, bit_valid, sin, data_ready, clr_overrun,
        output data_out, data_valid, busy, overrun, parity_err
    );
`else
    modport master (
        output start, msb_first, bit_valid, sin, data_ready, clr_overrun,
        input  data_out, data_valid, busy, overrun
    );

    modport slave (
        input  start, msb_first, bit_valid, sin, data_ready, clr_overrun,
        output data_out, data_valid, busy, overrun
    );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_deserializer.sv
// +----------------------------------------------------------------------------+
// | serial_deserializer : WIDTH-bit serial receiver, LSB/MSB-first per frame,   |
// | double-buffered output. Optional: DESER_PARITY_EN.      Revision: 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_deserializer_if.slave bus
);
    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             msb_q;
    logic             valid_q;
    logic             busy_q;
    logic             ovr_q;
    logic             w_out_free;
`ifdef DESER_PARITY_EN
    logic             perr_q;
`endif

    always_comb begin
        sreg_d = msb_q ? {sreg_q[WIDTH-2:0], bus.sin} : {bus.sin, sreg_q[WIDTH-1:1]};
    end

    // The holding register can take a new word if empty or being drained this cycle.
    assign w_out_free = !valid_q || bus.data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
            if (bus.clr_overrun) begin
                ovr_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RECV;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        msb_q   <= bus.msb_first;
                    end
                end
                S_RECV: begin
                    if (bus.bit_valid) begin
                        sreg_q <= sreg_d;
                        if (cnt_q == C_LAST) begin
                            cnt_q <= '0;
`ifdef DESER_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (w_out_free) begin
                                data_q  <= sreg_d;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef DESER_PARITY_EN
                S_PARITY: begin
                    if (bus.bit_valid) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (w_out_free) begin
                            data_q  <= sreg_q;
                            valid_q <= 1'b1;
                            perr_q  <= (^sreg_q) ^ bus.sin;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = ovr_q;
`ifdef DESER_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_deserializer.sv
// +----------------------------------------------------------------------------+
// | tb_serial_deserializer : directed bench with a bit-queue reference model.   |
// | Optional: DESER_PARITY_EN.                               Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_deserializer;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    serial_deserializer_if #(.WIDTH(W)) bus();

    serial_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: collect qualified bits in a queue, assemble the word
    // arithmetically once the frame length is reached.
    bit          m_busy  = 1'b0;
    bit          m_msb   = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_perr  = 1'b0;
    bit          m_free;
    int unsigned m_out   = 0;
    int unsigned m_word;
    bit          bits[$];
    int unsigned got[$];

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
            m_out   = 0;
            bits.delete();
        end else begin
            m_free = !m_valid || bus.data_ready;
            if (m_valid && bus.data_ready) m_valid = 1'b0;
            if (bus.clr_overrun) m_ovr = 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1'b1;
                    m_msb  = bus.msb_first;
                    bits.delete();
                end
            end else if (bus.bit_valid) begin
                bits.push_back(bus.sin);
                if (bits.size() == FRAME_LEN) begin
                    m_word = 0;
                    for (int i = 0; i < W; i++) begin
                        if (m_msb) m_word = m_word * 2 + int'(bits[i]);
                        else       m_word = m_word + (int'(bits[i]) << i);
                    end
                    m_busy = 1'b0;
                    if (m_free) begin
                        m_out   = m_word;
                        m_valid = 1'b1;
`ifdef DESER_PARITY_EN
                        m_perr  = ($countones(m_word) % 2 == 1) ^ bits[W];
`endif
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
            end
        end
    end

    // Transfers seen on the DUT side, recorded before this edge's updates.
    always @(posedge clk) begin
        if (chk_en && !rst && bus.data_valid === 1'b1 && bus.data_ready === 1'b1)
            got.push_back(32'(bus.data_out));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("model.data_valid", 32'(bus.data_valid), 32'(m_valid));
            check("model.data_out",   32'(bus.data_out),   m_out);
            check("model.busy",       32'(bus.busy),       32'(m_busy));
            check("model.overrun",    32'(bus.overrun),    32'(m_ovr));
`ifdef DESER_PARITY_EN
            check("model.parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.start     = 1'b0;
            bus.bit_valid = 1'b0;
            bus.sin       = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    // Returns at the negedge after the completing edge; the next call drives
    // start immediately, i.e. in the cycle right after completion.
    task automatic send_frame(input logic [31:0] word, input bit msb, input int nbits,
                              input int gap_at, input int gap_len, input bit par_flip,
                              input bit rdy_last, input bit clr_last);
        bit last;
        bus.start     = 1'b1;
        bus.msb_first = msb;
        bus.bit_valid = 1'b1;
        bus.sin       = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.start     = 1'b1;
        bus.msb_first = ~msb;
        for (int i = 0; i < nbits; i++) begin
            bus.bit_valid = 1'b1;
            bus.sin       = msb ? word[W-1-i] : word[i];
            last = (i == FRAME_LEN - 1);
            if (last && rdy_last) bus.data_ready  = 1'b1;
            if (last && clr_last) bus.clr_overrun = 1'b1;
            @(negedge clk);
            if (i == gap_at) begin
                bus.bit_valid = 1'b0;
                bus.sin       = ~bus.sin;
                repeat (gap_len) @(negedge clk);
            end
        end
`ifdef DESER_PARITY_EN
        if (nbits == W) begin
            bus.bit_valid = 1'b1;
            bus.sin       = (^word[W-1:0]) ^ par_flip;
            if (rdy_last) bus.data_ready  = 1'b1;
            if (clr_last) bus.clr_overrun = 1'b1;
            @(negedge clk);
        end
`endif
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        if (rdy_last) bus.data_ready  = 1'b0;
        if (clr_last) bus.clr_overrun = 1'b0;
    endtask

    task automatic pulse_ready();
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.msb_first   = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.sin         = 1'b0;
        bus.data_ready  = 1'b0;
        bus.clr_overrun = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset.data_valid", 32'(bus.data_valid), 32'h0);
        check("reset.data_out",   32'(bus.data_out),   32'h0);
        check("reset.busy",       32'(bus.busy),       32'h0);
        check("reset.overrun",    32'(bus.overrun),    32'h0);

        // LSB-first 1,0,1,0,0,1,0,1 -> 0xA5
        idle(1);
        send_frame(32'hA5, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        check("lsb.data_out",   32'(bus.data_out),   32'hA5);
        check("lsb.data_valid", 32'(bus.data_valid), 32'h1);
        check("lsb.busy",       32'(bus.busy),       32'h0);
        pulse_ready();
        check("lsb.drained", 32'(bus.data_valid), 32'h0);

        // MSB-first 0,0,1,1,1,1,0,0 with a 3-cycle gap after the 4th bit
        send_frame(32'h3C, 1'b1, W, 3, 3, 1'b0, 1'b0, 1'b0);
        check("msb.data_out", 32'(bus.data_out), 32'h3C);
        pulse_ready();

        // Overrun: 0x11 held, 0x22 dropped
        send_frame(32'h11, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h22, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        check("ovr.data_out", 32'(bus.data_out), 32'h11);
        check("ovr.overrun",  32'(bus.overrun),  32'h1);
        pulse_ready();
        check("ovr.drained", 32'(bus.data_valid), 32'h0);
        bus.clr_overrun = 1'b1;
        @(negedge clk);
        bus.clr_overrun = 1'b0;
        check("ovr.cleared", 32'(bus.overrun), 32'h0);

        // Load wins over a same-edge drain; then set wins over same-edge clear
        send_frame(32'h11, 1'b1, W, -1, 0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h77, 1'b1, W, -1, 0, 1'b0, 1'b1, 1'b0);
        check("loadwin.data_out", 32'(bus.data_out),   32'h77);
        check("loadwin.valid",    32'(bus.data_valid), 32'h1);
        check("loadwin.overrun",  32'(bus.overrun),    32'h0);
        send_frame(32'h99, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b1);
        check("setwin.overrun",  32'(bus.overrun),  32'h1);
        check("setwin.data_out", 32'(bus.data_out), 32'h77);
        bus.clr_overrun = 1'b1;
        pulse_ready();
        bus.clr_overrun = 1'b0;

        // Back-to-back with the consumer always ready
        got.delete();
        bus.data_ready = 1'b1;
        send_frame(32'h5A, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        send_frame(32'hC3, 1'b1, W, -1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        bus.data_ready = 1'b0;
        check("b2b.count",   32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("b2b.word0", got[0], 32'h5A);
            check("b2b.word1", got[1], 32'hC3);
        end
        check("b2b.overrun", 32'(bus.overrun), 32'h0);

        // Reset mid-frame with a word pending
        send_frame(32'h0F, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        send_frame(32'h0F, 1'b0, 4, -1, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.data_out",   32'(bus.data_out),   32'h0);
        check("rst.data_valid", 32'(bus.data_valid), 32'h0);
        check("rst.busy",       32'(bus.busy),       32'h0);
        check("rst.overrun",    32'(bus.overrun),    32'h0);
        send_frame(32'hFF, 1'b1, W, -1, 0, 1'b0, 1'b0, 1'b0);
        check("rst.fresh", 32'(bus.data_out), 32'hFF);
        pulse_ready();
        send_frame(32'h81, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        check("rst.next", 32'(bus.data_out), 32'h81);
        pulse_ready();

`ifdef DESER_PARITY_EN
        send_frame(32'hA5, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
        check("par.ok.data",  32'(bus.data_out),   32'hA5);
        check("par.ok.err",   32'(bus.parity_err), 32'h0);
        pulse_ready();
        send_frame(32'hA5, 1'b0, W, -1, 0, 1'b1, 1'b0, 1'b0);
        check("par.bad.err",  32'(bus.parity_err), 32'h1);
        pulse_ready();
`endif

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
